// File: rtl/cache_invalidate_hub.sv
// Write-invalidate broadcast hub: one round-robin-granted writer per cycle is
// fanned out to the invalidate FIFO of every other cache.
module cache_invalidate_hub #(
  parameter int NUM_CACHES = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CACHES-1:0]            change_valid,
  input  logic [NUM_CACHES*ADDR_WIDTH-1:0] change_addr,
  output logic [NUM_CACHES-1:0]            change_ready,
  output logic [NUM_CACHES-1:0]            inv_valid,
  output logic [NUM_CACHES*ADDR_WIDTH-1:0] inv_addr,
  input  logic [NUM_CACHES-1:0]            inv_ready,
  output logic                             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NUM_CACHES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CACHES - 1);

  logic [ADDR_WIDTH-1:0] mem    [NUM_CACHES][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr [NUM_CACHES];
  logic [PTR_W-1:0]      wr_ptr [NUM_CACHES];
  logic [CNT_W-1:0]      count  [NUM_CACHES];
  logic [IDX_W-1:0]      rr_ptr;

  logic [NUM_CACHES-1:0] full;
  logic [NUM_CACHES-1:0] eligible;
  logic [NUM_CACHES-1:0] push;
  logic [NUM_CACHES-1:0] pop;
  logic                  grant_any;
  logic [IDX_W-1:0]      grant_idx;
  logic [ADDR_WIDTH-1:0] grant_addr;
  int                    cand;

  // A source is eligible only if every other queue has room; the registered
  // count is used, so a pop this cycle cannot unblock a writer until next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    full     = '0;
    eligible = '0;
    for (int j = 0; j < NUM_CACHES; j++) begin
      full[j] = (count[j] == FULL_CNT);
    end
    for (int i = 0; i < NUM_CACHES; i++) begin
      eligible[i] = change_valid[i];
      for (int j = 0; j < NUM_CACHES; j++) begin
        if (j != i && full[j]) eligible[i] = 1'b0;
      end
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    // NOTE: blocking assignments here are intentional; grant_any must be seen
    // updated by later loop iterations to keep only the first hit.
    for (int k = 0; k < NUM_CACHES; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CACHES) cand = cand - NUM_CACHES;
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign grant_addr = change_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  always_comb begin
    change_ready = '0;
    push         = '0;
    pop          = '0;
    inv_valid    = '0;
    inv_addr     = '0;
    // Gated with reset so no accept is advertised while the block is held.
    if (grant_any && reset) change_ready[grant_idx] = 1'b1;
    for (int j = 0; j < NUM_CACHES; j++) begin
      push[j]      = grant_any && (grant_idx != IDX_W'(j));
      inv_valid[j] = (count[j] != '0);
      pop[j]       = inv_valid[j] && inv_ready[j];
      if (inv_valid[j]) inv_addr[j*ADDR_WIDTH +: ADDR_WIDTH] = mem[j][rd_ptr[j]];
    end
  end

  assign busy = |inv_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int j = 0; j < NUM_CACHES; j++) begin
        rd_ptr[j] <= '0;
        wr_ptr[j] <= '0;
        count[j]  <= '0;
      end
    end else begin
      if (grant_any) rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      for (int j = 0; j < NUM_CACHES; j++) begin
        if (push[j]) wr_ptr[j] <= wr_ptr[j] + PTR_W'(1);
        if (pop[j])  rd_ptr[j] <= rd_ptr[j] + PTR_W'(1);
        case ({push[j], pop[j]})
          2'b10:   count[j] <= count[j] + CNT_W'(1);
          2'b01:   count[j] <= count[j] - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only visible through
  // inv_addr while its count is non-zero, and counts are reset.
  always_ff @(posedge clock) begin
    for (int j = 0; j < NUM_CACHES; j++) begin
      if (push[j]) mem[j][wr_ptr[j]] <= grant_addr;
    end
  end

endmodule

// File: doc/cache_invalidate_hub.md
CACHE_INVALIDATE_HUB -- requirements
Module: cache_invalidate_hub

Interface
REQ-001 The parameters SHALL be:
- NUM_CACHES, default 2, number of caches (2..8).
- ADDR_WIDTH, default 16, invalidate address width.
- FIFO_DEPTH, default 4, entries per target queue (power of 2, at least 2).

REQ-002 The ports SHALL be:

| Port | Dir | Width | Meaning |
|---|---|---|---|
| clock | in | 1 | single clock, rising edge |
| reset | in | 1 | asynchronous, active-low |
| change_valid | in | NUM_CACHES | bit i = cache i presents a write |
| change_addr | in | NUM_CACHES*ADDR_WIDTH | slice i = cache i write address |
| change_ready | out | NUM_CACHES | bit i = cache i write accepted this cycle |
| inv_valid | out | NUM_CACHES | bit j = invalidate pending for cache j |
| inv_addr | out | NUM_CACHES*ADDR_WIDTH | slice j = address cache j must invalidate |
| inv_ready | in | NUM_CACHES | bit j = cache j consumes its invalidate |
| busy | out | 1 | any target queue non-empty |

REQ-003 The design SHALL use one clock domain; reset SHALL be asynchronous and active-low.

Function
REQ-004 Each cache j SHALL own one invalidate FIFO of FIFO_DEPTH entries, each entry ADDR_WIDTH wide.

REQ-005 Source i SHALL be eligible in a cycle when change_valid[i]=1 and every FIFO j≠i is non-full, using registered occupancy.

REQ-006 At most one source SHALL be granted per cycle, chosen round-robin:
- Grant the first eligible index at or after rr_ptr, searching upward with wrap.
- On a grant to g, rr_ptr SHALL become (g+1) mod NUM_CACHES.
- With no grant, rr_ptr SHALL hold.

REQ-007 change_ready SHALL be combinational; it SHALL be one-hot for the granted source and all-zero with no grant.

REQ-008 The accept handshake SHALL complete when change_valid[i] and change_ready[i] are both high on a rising edge. Sources SHALL hold valid and address stable until accepted.

REQ-009 On a grant to g, change_addr slice g SHALL be pushed into every FIFO j≠g on the same edge. FIFO g SHALL never receive its own address.

REQ-010 inv_valid[j] SHALL equal FIFO j non-empty. inv_addr slice j SHALL be the FIFO j head, and SHALL be zero when FIFO j is empty.

REQ-011 FIFO j SHALL pop on an edge where inv_valid[j] and inv_ready[j] are both high. inv_ready while empty SHALL be ignored.

REQ-012 Latency SHALL be 1 cycle: an address accepted on edge t SHALL appear at the outputs after edge t, provided the FIFO was empty.

REQ-013 Ordering SHALL be preserved: each target SHALL see invalidates in grant order.

REQ-014 Full handling:
- A full FIFO j SHALL block every source i≠j.
- A pop from FIFO j in the same cycle SHALL NOT unblock it until the next cycle.
- No push SHALL ever be dropped or overwritten.

REQ-015 A simultaneous push and pop on a non-full, non-empty FIFO SHALL keep its occupancy unchanged.

REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked in log2(FIFO_DEPTH)+1 bits, so full (count=FIFO_DEPTH) and empty (count=0) are distinct.

REQ-017 busy SHALL be a registered or combinational OR of all inv_valid bits, without added latency relative to inv_valid.

Reset
REQ-018 While reset=0, the block SHALL asynchronously force:
- all FIFO counts and pointers to 0,
- rr_ptr to 0,
- inv_valid and busy to 0, and inv_addr to 0.

REQ-019 change_ready SHALL be all-zero while reset=0.

REQ-020 Reset asserted mid-operation SHALL discard all queued invalidates. No output SHALL glitch high during reset.

REQ-021 After reset deasserts, the first rising edge SHALL behave as normal operation with rr_ptr=0.

Verification
REQ-022 Basic broadcast, NUM_CACHES=2:
- Stimulus: valid[0]=1, addr0=16'h1234 for one cycle.
- Response: change_ready=2'b01; next cycle inv_valid=2'b10 and inv_addr slice1=16'h1234.

REQ-023 Round robin, NUM_CACHES=4:
- Stimulus: valid=4'b1111 held, inv_ready all 1.
- Response: grants 0,1,2,3,0 on consecutive cycles.
- Response: cache 0 receives the addresses of 1,2,3 in that order.

REQ-024 Backpressure, FIFO_DEPTH=4:
- Stimulus: inv_ready[1]=0; cache 0 writes 5 times.
- Response: 4 accepted, the 5th held with change_ready[0]=0.
- Stimulus: raise inv_ready[1] for one cycle.
- Response: the 5th write is accepted on the following cycle, not the same one.

REQ-025 Self-exclusion:
- Stimulus: cache 1 write of 16'hBEEF with NUM_CACHES=3.
- Response: FIFOs 0 and 2 hold 16'hBEEF; inv_valid[1] stays 0.

REQ-026 Simultaneous push and pop:
- Stimulus: FIFO 1 with count 2, push and pop on the same edge.
- Response: count stays 2 and order is preserved.

REQ-027 Reset mid-operation:
- Stimulus: queues partially full; pull reset low between edges.
- Response: inv_valid=0 and busy=0 immediately.
- Response: after release, the first grant goes to the lowest-index valid source.
